m_ctrl_sequencer: RTL and testbench
===================================

# m_ctrl_sequencer

Multi-cycle control sequencer for the 8-bit CPU datapath: ROM, register file, ALU, data memory and the writeback mux. It replaces free-running per-clock PC update and combinational decode with a registered FSM. The FSM fetches each 16-bit instruction, decodes it, drives register, ALU, memory and mux controls one phase at a time, and updates the 6-bit PC. It also provides run/idle control, a sticky illegal-opcode halt, and a per-instruction retire pulse.

## Interface
- No parameters; widths are fixed: PC 6, instruction 16, data 8, register address 5, memory address 5.
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = execute; 0 = park in IDLE after the current instruction completes
- inst_in  in  16  ROM data, valid the cycle after rom_en
- alu_zero  in  1  ALU result == 0 for the current operands
- pc  out  6  instruction address to ROM
- rom_en  out  1  ROM read strobe
- ir  out  16  latched instruction
- read_address1, read_address2, write_address  out  5  register file addresses
- read_enable1, read_enable2, write_enable  out  1  register file controls
- imm_data  out  8  immediate operand
- mem_addr  out  5  data memory address (read and write)
- mem_write_enable  out  1  data memory write strobe
- mux_sel  out  1  writeback source: 0 = ALU, 1 = memory
- alu_sel  out  1  0 = add, 1 = subtract/compare
- state  out  3  current FSM state
- illegal  out  1  sticky illegal-opcode flag
- retired  out  1  one-cycle pulse when an instruction completes

## Operation
- Decode priority on ir:
  - ir[15]=1: BR (offset ir[14:10], compares ir[9:5] with ir[4:0])
  - ir[15:14]=01: JMP (target ir[5:0])
  - ir[15:13]=001: ADDI (rd = ir[12:8], imm = ir[7:0])
  - ir[15:10]=000001: ADD (rd = rs1 = ir[9:5], rs2 = ir[4:0])
  - 000010: LD (rd = ir[9:5], mem_addr = ir[4:0])
  - 000011: ST (rs1 = ir[9:5], mem_addr = ir[4:0])
  - any other encoding (000000, 0001xx): illegal
- States and encodings: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7.
- Transitions:
  - IDLE → FETCH when run=1; otherwise stay.
  - FETCH: rom_en=1 for one cycle → WAIT.
  - WAIT: ir ← inst_in at the end of the cycle → DECODE.
  - DECODE: drive read addresses, enables and imm_data, then go to EXEC. An illegal opcode sets illegal=1 and goes to HALT instead.
  - EXEC, ADD/ADDI → WB. LD/ST → MEM. BR: pc ← pc+offset if alu_zero=1, else pc+1. JMP: pc ← ir[5:0]. BR and JMP then exit.
  - MEM: LD → WB with mux_sel=1. ST: mem_write_enable=1 for one cycle, pc ← pc+1, then exit.
  - WB: write_enable=1 for one cycle, pc ← pc+1, then exit.
  - Exit goes to FETCH if run=1, else IDLE.
  - HALT is terminal; only rst leaves it.
- Control levels:
  - read_enable1=1 from DECODE to instruction end for ADD, ADDI, ST, BR.
  - read_enable2=1 for ADD and BR only; 0 for ADDI, which selects imm_data.
  - alu_sel=1 only in DECODE/EXEC of BR.
  - mux_sel=1 only in MEM/WB of LD.
  - write_enable and mem_write_enable are never high outside WB and MEM respectively.
- retired pulses in the final cycle of each instruction: WB for ADD/ADDI/LD, MEM for ST, EXEC for BR/JMP. An illegal opcode never retires.

## Timing
- Reset (async assert) drives: state=IDLE, pc=0, ir=0, all addresses 0, imm_data=0, every enable/strobe 0, mux_sel=0, alu_sel=0, illegal=0, retired=0.
- Cycles per instruction, FETCH to exit inclusive: ADD/ADDI 5, ST 5, LD 6, BR/JMP 4.
- PC arithmetic is 6-bit modulo 64. The BR offset is unsigned 5-bit, added to the address of the BR itself, so pc=62 with offset 3 gives 1.
- The ROM has one-cycle latency: pc is stable from FETCH through WAIT.
- run is sampled only in IDLE and at instruction exit. Deasserting run mid-instruction never aborts the instruction.
- rst asserted mid-instruction aborts immediately. Pending register and memory writes are cancelled, because the enables drop asynchronously.
- alu_zero is sampled only in EXEC of BR.

## Test plan
- Reset, run=1, ROM[0]=ADD r0,r1 (0x0401) → rom_en at cycle 1, write_enable high in cycle 5 with write_address=0, retired pulse, pc=1, state=FETCH.
- ROM[2]=JMP 5 (0x4005) → retired in EXEC, pc=5 after 4 cycles, no write_enable or mem_write_enable at any point.
- ROM[5]=BR +3 (0x8C00) with alu_zero=1 → pc=8. Repeat with alu_zero=0 → pc=6. BR at pc=62 with offset 3 and alu_zero=1 → pc=1.
- LD r2,[7] (0x0847) → mem_addr=7, mux_sel=1 in MEM and WB, write_enable in cycle 6 only. ST r3,[9] (0x0C69) → mem_write_enable one cycle in MEM, write_enable never high.
- inst_in=0x0000 → illegal=1, state=7, pc frozen, no retire. Asserting rst returns to IDLE with illegal=0.
- Drop run during EXEC of ADDI (0x2105) → WB completes, then IDLE with pc=1. Assert rst during WB → write_enable falls the same cycle and pc=0.

Source files
------------

// File: rtl/m_ctrl_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU: fetch, decode and phase-by-phase
// control of register file, ALU, data memory and writeback mux, with a 6-bit PC.
module m_ctrl_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] inst_in,
    input  logic        alu_zero,
    output logic [5:0]  pc,
    output logic        rom_en,
    output logic [15:0] ir,
    output logic [4:0]  read_address1,
    output logic [4:0]  read_address2,
    output logic [4:0]  write_address,
    output logic        read_enable1,
    output logic        read_enable2,
    output logic        write_enable,
    output logic [7:0]  imm_data,
    output logic [4:0]  mem_addr,
    output logic        mem_write_enable,
    output logic        mux_sel,
    output logic        alu_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  pc_reg;
    logic [15:0] ir_reg;
    logic        illegal_reg;

    logic is_br, is_jmp, is_addi, is_add, is_ld, is_st, is_bad;
    logic active;
    state_t exit_state;

    // Opcode decode in priority order; anything unmatched is illegal.
    always_comb begin
        is_br   = ir_reg[15];
        is_jmp  = (ir_reg[15:14] == 2'b01);
        is_addi = (ir_reg[15:13] == 3'b001);
        is_add  = (ir_reg[15:10] == 6'b000001);
        is_ld   = (ir_reg[15:10] == 6'b000010);
        is_st   = (ir_reg[15:10] == 6'b000011);
        is_bad  = !(is_br || is_jmp || is_addi || is_add || is_ld || is_st);
    end

    assign active     = (state_reg == S_DECODE) || (state_reg == S_EXEC) ||
                        (state_reg == S_MEM) || (state_reg == S_WB);
    assign exit_state = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  state_next = S_WAIT;
            S_WAIT:   state_next = S_DECODE;
            S_DECODE: state_next = is_bad ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_add || is_addi)   state_next = S_WB;
                else if (is_ld || is_st) state_next = S_MEM;
                else                     state_next = exit_state;
            end
            S_MEM:    state_next = is_ld ? S_WB : exit_state;
            S_WB:     state_next = exit_state;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs are purely combinational from state and ir, so reset kills strobes at once.
    always_comb begin
        rom_en           = 1'b0;
        read_address1    = 5'd0;
        read_address2    = 5'd0;
        write_address    = 5'd0;
        read_enable1     = 1'b0;
        read_enable2     = 1'b0;
        write_enable     = 1'b0;
        imm_data         = 8'd0;
        mem_addr         = 5'd0;
        mem_write_enable = 1'b0;
        mux_sel          = 1'b0;
        alu_sel          = 1'b0;
        retired          = 1'b0;
        if (active) begin
            if (is_br) begin
                read_address1 = ir_reg[9:5];
                read_address2 = ir_reg[4:0];
                read_enable1  = 1'b1;
                read_enable2  = 1'b1;
            end
            if (is_addi) begin
                read_address1 = ir_reg[12:8];
                write_address = ir_reg[12:8];
                read_enable1  = 1'b1;
                imm_data      = ir_reg[7:0];
            end
            if (is_add) begin
                read_address1 = ir_reg[9:5];
                read_address2 = ir_reg[4:0];
                write_address = ir_reg[9:5];
                read_enable1  = 1'b1;
                read_enable2  = 1'b1;
            end
            if (is_ld) begin
                write_address = ir_reg[9:5];
                mem_addr      = ir_reg[4:0];
            end
            if (is_st) begin
                read_address1 = ir_reg[9:5];
                read_enable1  = 1'b1;
                mem_addr      = ir_reg[4:0];
            end
        end
        case (state_reg)
            S_FETCH:  rom_en = 1'b1;
            S_DECODE: alu_sel = is_br;
            S_EXEC: begin
                alu_sel = is_br;
                retired = is_br || is_jmp;
            end
            S_MEM: begin
                mux_sel          = is_ld;
                mem_write_enable = is_st;
                retired          = is_st;
            end
            S_WB: begin
                write_enable = 1'b1;
                mux_sel      = is_ld;
                retired      = 1'b1;
            end
            default: ;
        endcase
    end

    // PC only moves on the retiring cycle, so it stays stable across FETCH/WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg      <= 6'd0;
            ir_reg      <= 16'd0;
            illegal_reg <= 1'b0;
        end else begin
            if (state_reg == S_WAIT) ir_reg <= inst_in;
            if (state_reg == S_DECODE && is_bad) illegal_reg <= 1'b1;
            if (retired) begin
                if (is_jmp)
                    pc_reg <= ir_reg[5:0];
                else if (is_br && alu_zero)
                    pc_reg <= pc_reg + {1'b0, ir_reg[14:10]};
                else
                    pc_reg <= pc_reg + 6'd1;
            end
        end
    end

    assign pc      = pc_reg;
    assign ir      = ir_reg;
    assign illegal = illegal_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_m_ctrl_sequencer.sv
// Self-checking bench for m_ctrl_sequencer: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_m_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [15:0] inst_in = 16'd0;
    logic        alu_zero = 1'b0;
    logic [5:0]  pc;
    logic        rom_en;
    logic [15:0] ir;
    logic [4:0]  read_address1, read_address2, write_address;
    logic        read_enable1, read_enable2, write_enable;
    logic [7:0]  imm_data;
    logic [4:0]  mem_addr;
    logic        mem_write_enable, mux_sel, alu_sel;
    logic [2:0]  state;
    logic        illegal, retired;

    int tests = 0;
    int fails = 0;
    logic [5:0] exp_pc = 6'd0;

    localparam int K_BR = 0, K_JMP = 1, K_ADDI = 2, K_ADD = 3, K_LD = 4, K_ST = 5;

    m_ctrl_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .inst_in(inst_in), .alu_zero(alu_zero),
        .pc(pc), .rom_en(rom_en), .ir(ir),
        .read_address1(read_address1), .read_address2(read_address2), .write_address(write_address),
        .read_enable1(read_enable1), .read_enable2(read_enable2), .write_enable(write_enable),
        .imm_data(imm_data), .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
        .mux_sel(mux_sel), .alu_sel(alu_sel), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rand_legal(input int k);
        logic [15:0] r;
        r = 16'($urandom);
        case (k)
            K_BR:    r[15] = 1'b1;
            K_JMP:   r[15:14] = 2'b01;
            K_ADDI:  r[15:13] = 3'b001;
            K_ADD:   r[15:10] = 6'b000001;
            K_LD:    r[15:10] = 6'b000010;
            default: r[15:10] = 6'b000011;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_from_reset();
        @(negedge clk);
        rst = 1'b0; run = 1'b1; inst_in = 16'd0; alu_zero = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_pc = 6'd0;
        step();
    endtask

    // Runs one instruction from its FETCH cycle to the following FETCH/IDLE cycle.
    task automatic do_instr(input logic [15:0] instr, input logic az, input bit drop, output bit ok);
        int kind, exp_cyc, cyc, we_n, we_cyc, mwe_n, mwe_cyc;
        logic [4:0] exp_wa, exp_ra1, exp_ra2, wa_seen, ma_seen, ra1_seen, ra2_seen;
        logic exp_re1, exp_re2, exp_alu, re1_seen, re2_seen, alu_seen, mux_seen, exp_run;
        logic [7:0] imm_seen;
        logic [5:0] exp_next;
        bit done;
        exp_wa = 5'd0; exp_ra1 = 5'd0; exp_ra2 = 5'd0;
        exp_re1 = 1'b0; exp_re2 = 1'b0; exp_alu = 1'b0;
        exp_cyc = 5; exp_next = exp_pc + 6'd1;
        if (instr[15]) begin
            kind = K_BR; exp_cyc = 4; exp_re1 = 1'b1; exp_re2 = 1'b1; exp_alu = 1'b1;
            exp_ra1 = instr[9:5]; exp_ra2 = instr[4:0];
            exp_next = az ? exp_pc + 6'(instr[14:10]) : exp_pc + 6'd1;
        end else if (instr[14]) begin
            kind = K_JMP; exp_cyc = 4; exp_next = instr[5:0];
        end else if (instr[13]) begin
            kind = K_ADDI; exp_wa = instr[12:8]; exp_re1 = 1'b1; exp_ra1 = instr[12:8];
        end else if (instr[12:10] == 3'b001) begin
            kind = K_ADD; exp_wa = instr[9:5]; exp_re1 = 1'b1; exp_re2 = 1'b1;
            exp_ra1 = instr[9:5]; exp_ra2 = instr[4:0];
        end else if (instr[12:10] == 3'b010) begin
            kind = K_LD; exp_cyc = 6; exp_wa = instr[9:5];
        end else begin
            kind = K_ST; exp_re1 = 1'b1; exp_ra1 = instr[9:5];
        end

        tests++;
        if (state !== 3'd1 || rom_en !== 1'b1 || pc !== exp_pc) begin
            fails++;
            $display("FAIL fetch: state=%0d rom_en=%b pc=%0d, required state=1 rom_en=1 pc=%0d",
                     state, rom_en, pc, exp_pc);
        end
        inst_in = instr; alu_zero = az;
        cyc = 1; done = 0; we_n = 0; we_cyc = 0; mwe_n = 0; mwe_cyc = 0;
        wa_seen = 5'd0; ma_seen = 5'd0; ra1_seen = 5'd0; ra2_seen = 5'd0; imm_seen = 8'd0;
        re1_seen = 1'b0; re2_seen = 1'b0; alu_seen = 1'b0; mux_seen = 1'b0;
        while (!done && cyc <= 8) begin
            if (write_enable === 1'b1) begin we_n++; we_cyc = cyc; wa_seen = write_address; end
            if (mem_write_enable === 1'b1) begin mwe_n++; mwe_cyc = cyc; end
            if (cyc == 2) begin
                tests++;
                if (state !== 3'd2 || rom_en !== 1'b0 || pc !== exp_pc) begin
                    fails++;
                    $display("FAIL wait: state=%0d rom_en=%b pc=%0d, required state=2 rom_en=0 pc=%0d",
                             state, rom_en, pc, exp_pc);
                end
            end
            if (cyc == 3) begin
                re1_seen = read_enable1; re2_seen = read_enable2; alu_seen = alu_sel;
                ra1_seen = read_address1; ra2_seen = read_address2; imm_seen = imm_data;
            end
            if (cyc == 5) begin ma_seen = mem_addr; mux_seen = mux_sel; end
            if (cyc == 4 && drop) run = 1'b0;
            if (retired === 1'b1) done = 1;
            else begin step(); cyc++; end
        end
        exp_run = run;

        tests++;
        if (!done || cyc != exp_cyc) begin
            fails++;
            $display("FAIL cycles %h: retired at cycle %0d (seen=%0d), required %0d", instr, cyc, done, exp_cyc);
        end
        tests++;
        if ((kind == K_ADD || kind == K_ADDI || kind == K_LD) ?
            (we_n != 1 || we_cyc != exp_cyc || wa_seen !== exp_wa) : (we_n != 0)) begin
            fails++;
            $display("FAIL regwrite %h: count=%0d cycle=%0d addr=%0d, required addr=%0d in last cycle (kind %0d)",
                     instr, we_n, we_cyc, wa_seen, exp_wa, kind);
        end
        tests++;
        if ((kind == K_ST) ? (mwe_n != 1 || mwe_cyc != 5) : (mwe_n != 0)) begin
            fails++;
            $display("FAIL memwrite %h: count=%0d cycle=%0d, required kind %0d", instr, mwe_n, mwe_cyc, kind);
        end
        if (kind == K_LD || kind == K_ST) begin
            tests++;
            if (ma_seen !== instr[4:0] || mux_seen !== (kind == K_LD)) begin
                fails++;
                $display("FAIL memphase %h: mem_addr=%0d mux_sel=%b, required mem_addr=%0d mux_sel=%b",
                         instr, ma_seen, mux_seen, instr[4:0], kind == K_LD);
            end
        end
        tests++;
        if (re1_seen !== exp_re1 || re2_seen !== exp_re2 || alu_seen !== exp_alu ||
            (exp_re1 && ra1_seen !== exp_ra1) || (exp_re2 && ra2_seen !== exp_ra2) ||
            (kind == K_ADDI && imm_seen !== instr[7:0])) begin
            fails++;
            $display("FAIL decode %h: re1=%b re2=%b alu=%b ra1=%0d ra2=%0d imm=%h, required re1=%b re2=%b alu=%b ra1=%0d ra2=%0d",
                     instr, re1_seen, re2_seen, alu_seen, ra1_seen, ra2_seen, imm_seen,
                     exp_re1, exp_re2, exp_alu, exp_ra1, exp_ra2);
        end
        ok = done;
        if (done) begin
            step();
            tests++;
            if (state !== (exp_run ? 3'd1 : 3'd0) || pc !== exp_next) begin
                fails++;
                $display("FAIL next %h: state=%0d pc=%0d, required state=%0d pc=%0d",
                         instr, state, pc, exp_run ? 1 : 0, exp_next);
            end
            exp_pc = exp_next;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; inst_in = 16'hFFFF; alu_zero = 1'b1;
        #3;
        tests++;
        if ({pc, rom_en, ir, read_address1, read_address2, write_address, read_enable1, read_enable2,
             write_enable, imm_data, mem_addr, mem_write_enable, mux_sel, alu_sel, state, illegal, retired} !== 62'd0) begin
            fails++;
            $display("FAIL reset_outputs: state=%0d pc=%0d ir=%h rom_en=%b we=%b, required all zero",
                     state, pc, ir, rom_en, write_enable);
        end
        run = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (3) step();
        tests++;
        if (state !== 3'd0 || rom_en !== 1'b0 || pc !== 6'd0) begin
            fails++;
            $display("FAIL idle_hold: state=%0d rom_en=%b pc=%0d, required state=0 rom_en=0 pc=0", state, rom_en, pc);
        end
    endtask

    task automatic test_add_first();
        bit ok;
        start_from_reset();
        do_instr(16'h0401, 1'b0, 1'b0, ok);
        tests++;
        if (pc !== 6'd1 || state !== 3'd1) begin
            fails++;
            $display("FAIL add_first: pc=%0d state=%0d, required pc=1 state=1", pc, state);
        end
    endtask

    task automatic test_jmp_br();
        bit ok;
        do_instr(16'h2105, 1'b0, 1'b0, ok);
        do_instr(16'h4005, 1'b0, 1'b0, ok);
        tests++;
        if (pc !== 6'd5) begin fails++; $display("FAIL jmp5: pc=%0d, required 5", pc); end
        do_instr(16'h8C00, 1'b1, 1'b0, ok);
        tests++;
        if (pc !== 6'd8) begin fails++; $display("FAIL br_taken: pc=%0d, required 8", pc); end
        do_instr(16'h4005, 1'b0, 1'b0, ok);
        do_instr(16'h8C00, 1'b0, 1'b0, ok);
        tests++;
        if (pc !== 6'd6) begin fails++; $display("FAIL br_not_taken: pc=%0d, required 6", pc); end
        do_instr(16'h403E, 1'b0, 1'b0, ok);
        do_instr(16'h8C00, 1'b1, 1'b0, ok);
        tests++;
        if (pc !== 6'd1) begin fails++; $display("FAIL br_wrap: pc=%0d, required 1", pc); end
    endtask

    task automatic test_ld_st();
        bit ok;
        do_instr(16'h0847, 1'b0, 1'b0, ok);
        do_instr(16'h0C69, 1'b0, 1'b0, ok);
        tests++;
        if (pc !== 6'd3) begin fails++; $display("FAIL ld_st_pc: pc=%0d, required 3", pc); end
    endtask

    task automatic test_illegal();
        logic [15:0] bad;
        int ret_n;
        for (int i = 0; i < 4; i++) begin
            bad = 16'($urandom);
            if (i == 0) bad = 16'h0000;
            else if (i[0]) bad[15:12] = 4'b0001;
            else bad[15:10] = 6'b000000;
            start_from_reset();
            inst_in = bad;
            ret_n = 0;
            for (int c = 0; c < 9; c++) begin
                step();
                if (retired === 1'b1) ret_n++;
            end
            tests++;
            if (state !== 3'd7 || illegal !== 1'b1 || pc !== 6'd0 || ret_n != 0) begin
                fails++;
                $display("FAIL illegal %h: state=%0d illegal=%b pc=%0d retires=%0d, required state=7 illegal=1 pc=0 retires=0",
                         bad, state, illegal, pc, ret_n);
            end
            rst = 1'b0;
            #1;
            tests++;
            if (state !== 3'd0 || illegal !== 1'b0) begin
                fails++;
                $display("FAIL illegal_clear: state=%0d illegal=%b, required 0 0", state, illegal);
            end
        end
    endtask

    task automatic test_run_drop();
        bit ok;
        start_from_reset();
        do_instr(16'h2105, 1'b0, 1'b1, ok);
        repeat (3) step();
        tests++;
        if (state !== 3'd0 || pc !== 6'd1 || rom_en !== 1'b0) begin
            fails++;
            $display("FAIL run_drop: state=%0d pc=%0d rom_en=%b, required state=0 pc=1 rom_en=0", state, pc, rom_en);
        end
    endtask

    task automatic test_rst_mid();
        run = 1'b1;
        step();
        inst_in = 16'h0401;
        repeat (4) step();
        tests++;
        if (state !== 3'd6 || write_enable !== 1'b1 || write_address !== 5'd0) begin
            fails++;
            $display("FAIL wb_reached: state=%0d we=%b wa=%0d, required state=6 we=1 wa=0", state, write_enable, write_address);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (write_enable !== 1'b0 || state !== 3'd0 || pc !== 6'd0 || retired !== 1'b0) begin
            fails++;
            $display("FAIL rst_abort: we=%b state=%0d pc=%0d retired=%b, required 0 0 0 0", write_enable, state, pc, retired);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_random();
        bit ok;
        bit drop;
        logic [15:0] instr;
        start_from_reset();
        for (int n = 0; n < 150; n++) begin
            instr = rand_legal($urandom_range(0, 5));
            drop = ($urandom_range(0, 9) == 0);
            do_instr(instr, 1'($urandom), drop, ok);
            if (!ok) start_from_reset();
            else if (run == 1'b0) begin
                repeat ($urandom_range(0, 2)) step();
                run = 1'b1;
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_first();
        test_jmp_br();
        test_ld_st();
        test_illegal();
        test_run_drop();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
